// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: instruction encodings shared by the fetch and decode stages.
package fetch_unit_pkg;
  localparam logic [5:0] NOP_OP = 6'h13;
  localparam logic [63:0] NOP_BUNDLE = {NOP_OP, 26'b0, NOP_OP, 26'b0};
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: fetches 64-bit bundles from a synchronous BRAM, holds on interlock, redirects on branch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              interlock,
  input  logic              branch_flag,
  input  logic [31:0]       branch_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [63:0]       imem_dout,
  output logic [31:0]       pc,
  output logic [63:0]       inst
);
  logic [31:0] fpc_q, fpc_d, pc_q, pc_d;
  logic        v_q, v_d, held_q, held_d;
  logic [63:0] hold_q, hold_d;
  assign imem_addr = fpc_q[ADDR_W-1:0];
  assign imem_en   = ~held_q;
  assign pc        = v_q ? pc_q : 32'd0;
  assign inst      = ~v_q ? NOP_BUNDLE : (held_q ? hold_q : imem_dout);
  always_comb begin
    fpc_d  = fpc_q;
    pc_d   = pc_q;
    v_d    = v_q;
    held_d = held_q;
    hold_d = hold_q;
    if (branch_flag) begin
      fpc_d  = branch_pc;
      v_d    = 1'b0;
      held_d = 1'b0;
    end else if (interlock) begin
      // A bubble already shows a constant Nop, so only a valid bundle is captured.
      if (v_q && !held_q) begin
        hold_d = imem_dout;
        held_d = 1'b1;
      end
    end else begin
      pc_d   = fpc_q;
      v_d    = 1'b1;
      fpc_d  = fpc_q + 32'd1;
      held_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fpc_q  <= RESET_PC;
      pc_q   <= 32'd0;
      v_q    <= 1'b0;
      held_q <= 1'b0;
      hold_q <= NOP_BUNDLE;
    end else begin
      fpc_q  <= fpc_d;
      pc_q   <= pc_d;
      v_q    <= v_d;
      held_q <= held_d;
      hold_q <= hold_d;
    end
  end
endmodule
